// File: rtl/mem_fifo_fetch_ctrl_pkg.sv
// Shared definitions for the memory-to-FIFO fetch path.
// Holds the fetch FSM state type, default widths/depths and a clog2 helper.
package mem_fifo_fetch_ctrl_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefFifoDepth = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } fetch_state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_fifo_fetch_ctrl.sv
// Burst fetch controller: reads `length` words starting at `base_addr` from a synchronous
// memory (1-cycle read latency) and pushes each returned word into a FIFO, never issuing a
// read unless the FIFO is guaranteed to have room for it.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, base_addr,    transfer request and configuration, sampled in idle only
//   length
//   abort                stop issuing reads (fetch state only)
//   mem_rd_en, mem_addr  memory read strobe and address
//   mem_rd_data          read data, valid one cycle after mem_rd_en
//   fifo_level           committed FIFO occupancy
//   fifo_wr_en,          FIFO push strobe and data
//   fifo_wr_data
//   busy, done, aborted  status: not idle, one-cycle completion pulse, ended by abort
module mem_fifo_fetch_ctrl
  import mem_fifo_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 9,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned LVL_WIDTH  = clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  abort,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic [LVL_WIDTH-1:0]  fifo_level,
  output logic                  fifo_wr_en,
  output logic [DATA_WIDTH-1:0] fifo_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted
);

  localparam logic [LVL_WIDTH:0] DepthLvl = (LVL_WIDTH + 1)'(FIFO_DEPTH);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  wr_en_q;
  logic                  aborted_q;
  logic                  space_ok;
  logic                  issue;
  logic                  last_issue;

  // level + in-flight word + this read must fit: level + wr_en + 1 <= depth.
  assign space_ok   = ({1'b0, fifo_level} + {{LVL_WIDTH{1'b0}}, wr_en_q}) < DepthLvl;
  assign issue      = (state_q == StFetch) && !abort && space_ok;
  assign last_issue = issue && (cnt_q == (len_q - LEN_WIDTH'(1)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (length == '0) ? StDone : StFetch;
      end
      StFetch: begin
        if (abort || last_issue) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    mem_rd_en    = issue;
    mem_addr     = base_q + ADDR_WIDTH'(cnt_q);
    fifo_wr_en   = wr_en_q;
    fifo_wr_data = mem_rd_data;
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    aborted      = (state_q == StDone) && aborted_q;
  end

  // Configuration capture, issue counter and the one-stage read-valid pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      wr_en_q <= issue;
      if ((state_q == StIdle) && start) begin
        base_q    <= base_addr;
        len_q     <= length;
        cnt_q     <= '0;
        aborted_q <= 1'b0;
      end else if (issue) begin
        cnt_q <= cnt_q + LEN_WIDTH'(1);
      end
      if ((state_q == StFetch) && abort) aborted_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_fifo_fetch_ctrl.sv
// Directed bench for mem_fifo_fetch_ctrl with a memory model, a FIFO level model and an
// address/data scoreboard.
module tb_mem_fifo_fetch_ctrl;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int LW = 9;
  localparam int FD = 16;
  localparam int VW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic          abort = 1'b0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [VW-1:0] fifo_level;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          pop = 1'b0;

  always #5 clk = ~clk;

  mem_fifo_fetch_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW),
    .FIFO_DEPTH(FD),
    .LVL_WIDTH (VW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .abort       (abort),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .fifo_level  (fifo_level),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted)
  );

  function automatic logic [7:0] mem_word(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h3C;
  endfunction

  // Synchronous memory, one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);
  end

  // FIFO occupancy: push commits at the edge, consumer pops when the bench asks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_level <= '0;
    else fifo_level <= fifo_level + VW'(fifo_wr_en) - VW'(pop);
  end

  int            n_err = 0;
  int            n_chk = 0;
  int            cyc;
  int            rd_count, wr_count, done_count, done_cyc, pop_left;
  int            snap_rd, snap_wr, snap_lvl;
  logic          done_ab;
  logic [63:0]   rd_mask, wr_mask, busy_mask;
  logic [VW-1:0] max_lvl;
  logic [7:0]    exp_addr[$];
  logic [7:0]    exp_data[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle monitor: scoreboard pops for reads and pushes, plus timing masks.
  task automatic observe();
    logic [7:0] e;
    if (mem_rd_en) begin
      rd_count++;
      if (cyc < 64) rd_mask[cyc] = 1'b1;
      n_chk++;
      assert (exp_addr.size() != 0)
      else begin
        n_err++;
        $error("FAIL rd_extra: observed read at %0h expected no read", mem_addr);
      end
      if (exp_addr.size() != 0) begin
        e = exp_addr.pop_front();
        chk("rd_addr", 64'(mem_addr), 64'(e));
      end
    end
    if (fifo_wr_en) begin
      wr_count++;
      if (cyc < 64) wr_mask[cyc] = 1'b1;
      n_chk++;
      assert (exp_data.size() != 0)
      else begin
        n_err++;
        $error("FAIL wr_extra: observed push %0h expected no push", fifo_wr_data);
      end
      if (exp_data.size() != 0) begin
        e = exp_data.pop_front();
        chk("wr_data", 64'(fifo_wr_data), 64'(e));
      end
    end
    if (busy && cyc < 64) busy_mask[cyc] = 1'b1;
    if (done) begin
      done_count++;
      done_cyc = cyc;
      done_ab  = aborted;
    end
    if (fifo_level > max_lvl) max_lvl = fifo_level;
  endtask

  // One transfer: start is applied before edge 0, so the loop's first cycle is cycle 1.
  task automatic run(input logic [7:0] base, input logic [8:0] len, input int n_exp,
                     input int abort_at, input int restart_at, input int pop_at,
                     input int budget);
    rd_count = 0; wr_count = 0; done_count = 0; done_cyc = -1; done_ab = 1'b0;
    rd_mask = '0; wr_mask = '0; busy_mask = '0; max_lvl = '0; pop_left = 0;
    snap_rd = -1; snap_wr = -1; snap_lvl = -1;
    for (int i = 0; i < n_exp; i++) begin
      exp_addr.push_back(base + 8'(i));
      exp_data.push_back(mem_word(base + 8'(i)));
    end
    start = 1'b1; base_addr = base; length = len; abort = 1'b0; pop = 1'b0; cyc = 0;
    while (cyc < budget && !(done_count > 0 && cyc >= done_cyc + 2)) begin
      @(posedge clk);
      #1;
      if (pop) pop_left--;
      cyc++;
      start = (cyc == restart_at);
      if (cyc == restart_at) begin
        base_addr = 8'h80;
        length    = 9'd9;
      end
      abort = (cyc == abort_at);
      if (cyc == pop_at) pop_left = 4;
      pop = (pop_left > 0);
      #1;
      observe();
      if (cyc == pop_at - 1) begin
        snap_rd = rd_count; snap_wr = wr_count; snap_lvl = int'(fifo_level);
      end
    end
    start = 1'b0; abort = 1'b0; pop = 1'b0;
    chk("addr_queue_left", 64'(exp_addr.size()), 64'd0);
    chk("data_queue_left", 64'(exp_data.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; pop = 1'b0; pop_left = 0;
    exp_addr.delete();
    exp_data.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    #1;
    chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);

    // Plain burst
    run(8'h10, 9'd3, 3, -1, -1, -1, 30);
    chk("plain_rd_cycles", rd_mask, 64'h0E);
    chk("plain_wr_cycles", wr_mask, 64'h1C);
    chk("plain_done_cyc", 64'(done_cyc), 64'd5);
    chk("plain_done_count", 64'(done_count), 64'd1);
    chk("plain_aborted", 64'(done_ab), 64'd0);
    chk("plain_busy_cycles", busy_mask, 64'h3E);

    // Back-pressure with no consumer, then drain four entries
    do_reset();
    run(8'h30, 9'd20, 20, -1, -1, 26, 60);
    chk("bp_reads_at_stall", 64'(snap_rd), 64'd16);
    chk("bp_pushes_at_stall", 64'(snap_wr), 64'd16);
    chk("bp_level_at_stall", 64'(snap_lvl), 64'd16);
    chk("bp_reads_total", 64'(rd_count), 64'd20);
    chk("bp_pushes_total", 64'(wr_count), 64'd20);
    chk("bp_max_level", 64'(max_lvl), 64'd16);
    chk("bp_done_cyc", 64'(done_cyc), 64'd32);
    chk("bp_aborted", 64'(done_ab), 64'd0);

    // Address wrap
    do_reset();
    run(8'hFE, 9'd4, 4, -1, -1, -1, 30);
    chk("wrap_rd_cycles", rd_mask, 64'h1E);
    chk("wrap_done_cyc", 64'(done_cyc), 64'd6);

    // Abort in cycle 4
    run(8'h50, 9'd10, 3, 4, -1, -1, 30);
    chk("abort_rd_cycles", rd_mask, 64'h0E);
    chk("abort_wr_cycles", wr_mask, 64'h1C);
    chk("abort_done_cyc", 64'(done_cyc), 64'd6);
    chk("abort_aborted", 64'(done_ab), 64'd1);

    // Zero length
    run(8'h20, 9'd0, 0, -1, -1, -1, 10);
    chk("zero_done_cyc", 64'(done_cyc), 64'd1);
    chk("zero_reads", 64'(rd_count), 64'd0);
    chk("zero_busy_cycles", busy_mask, 64'h02);
    chk("zero_aborted", 64'(done_ab), 64'd0);

    // Start while busy is ignored
    run(8'h40, 9'd5, 5, -1, 2, -1, 30);
    chk("restart_reads", 64'(rd_count), 64'd5);
    chk("restart_done_cyc", 64'(done_cyc), 64'd7);

    // Asynchronous reset mid-fetch, between clock edges
    start = 1'b1; base_addr = 8'h20; length = 9'd10;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("pre_rst_rd_en", 64'(mem_rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_fifo_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_aborted", 64'(aborted), 64'd0);
    do_reset();
    run(8'h10, 9'd2, 2, -1, -1, -1, 30);
    chk("post_rst_rd_cycles", rd_mask, 64'h06);
    chk("post_rst_wr_cycles", wr_mask, 64'h0C);
    chk("post_rst_done_cyc", 64'(done_cyc), 64'd4);
    chk("post_rst_aborted", 64'(done_ab), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
